// File: rtl/digit_scan_driver.sv
// Four-digit seven-segment scan driver: dwell counter, one-hot digit select,
// active-low anode strobes with leading-zero blanking, and a frame-synchronous value buffer.
module digit_scan_driver #(
    parameter int DWELL = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        lz_blank,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  sel,
    output logic [15:0] disp_val,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q,  cnt_d;
    logic [3:0]    sel_q,  sel_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          full_q, full_d;
    logic          fd_q,   fd_d;

    logic          dwell_wrap;
    logic          frame_wrap;
    logic          accept;
    logic [3:0]    blank;

    assign dwell_wrap = en && (cnt_q == CNT_LAST);
    assign frame_wrap = dwell_wrap && sel_q[3];
    assign accept     = load_valid && !full_q;

    always_comb begin
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        disp_d = disp_q;
        pend_d = pend_q;
        full_d = full_q;
        fd_d   = frame_wrap;

        if (en) begin
            cnt_d = dwell_wrap ? '0 : cnt_q + 1'b1;
        end
        if (dwell_wrap) begin
            sel_d = {sel_q[2:0], sel_q[3]};
        end

        // A swap needs pending full, and an accept needs it empty, so the
        // two never collide on the same edge.
        if (frame_wrap && full_q) begin
            disp_d = pend_q;
            full_d = 1'b0;
        end
        if (accept) begin
            pend_d = load_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sel_q  <= 4'b0001;
            disp_q <= 16'h0000;
            pend_q <= 16'h0000;
            full_q <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            disp_q <= disp_d;
            pend_q <= pend_d;
            full_q <= full_d;
            fd_q   <= fd_d;
        end
    end

    // Digit k is a leading zero when it and every digit above it are zero.
    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign blank[gi] = lz_blank && (disp_q[15:4*gi] == '0);
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign an_n[gi] = !en || !sel_q[gi] || blank[gi];
        end
    endgenerate

    assign load_ready = !full_q;
    assign sel        = sel_q;
    assign disp_val   = disp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: DWELL=4 and DWELL=1 instances against a frame-position model.
module tb_digit_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, lz_blank, load_valid;
    logic [15:0] load_data;

    logic        a_rdy, a_fd, b_rdy, b_fd;
    logic [3:0]  a_sel, a_an, b_sel, b_an;
    logic [15:0] a_disp, b_disp;

    digit_scan_driver #(.DWELL(4)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .lz_blank(lz_blank),
        .load_valid(load_valid), .load_data(load_data), .load_ready(a_rdy),
        .sel(a_sel), .disp_val(a_disp), .an_n(a_an), .frame_done(a_fd)
    );

    digit_scan_driver #(.DWELL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .lz_blank(lz_blank),
        .load_valid(load_valid), .load_data(load_data), .load_ready(b_rdy),
        .sel(b_sel), .disp_val(b_disp), .an_n(b_an), .frame_done(b_fd)
    );

    int errors = 0;
    int checks = 0;

    // Model: position inside the frame in clock ticks, plus displayed/pending values.
    int          m_ticks [2];
    logic [15:0] m_disp  [2];
    logic [15:0] m_pend  [2];
    bit          m_full  [2];
    bit          m_fd    [2];

    function automatic int dw(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [3:0] m_sel(input int i);
        int digit;
        digit = (m_ticks[i] / dw(i)) % 4;
        return 4'(1 << digit);
    endfunction

    function automatic logic [3:0] m_an(input int i);
        logic [3:0] r;
        logic [3:0] s;
        int digit;
        s = m_sel(i);
        for (int k = 0; k < 4; k++) begin
            digit = k;
            r[k] = !en || !s[k] ||
                   (lz_blank && digit > 0 && ((32'(m_disp[i]) >> (4 * digit)) == 0));
        end
        return r;
    endfunction

    task automatic model_step(input int i);
        bit wrap;
        bit acc;
        if (!rst_n) begin
            m_ticks[i] = 0;
            m_disp[i]  = 16'h0000;
            m_full[i]  = 1'b0;
            m_fd[i]    = 1'b0;
        end else begin
            wrap = en && (((m_ticks[i] + 1) % (4 * dw(i))) == 0);
            acc  = load_valid && !m_full[i];
            m_fd[i] = wrap;
            if (en) m_ticks[i] = (m_ticks[i] + 1) % (4 * dw(i));
            if (wrap && m_full[i]) begin
                m_disp[i] = m_pend[i];
                m_full[i] = 1'b0;
            end
            if (acc) begin
                m_pend[i] = load_data;
                m_full[i] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input string tag, input logic [3:0] sel,
                            input logic [3:0] an, input logic rdy, input logic fd,
                            input logic [15:0] disp);
        check({tag, ".sel"},   32'(sel),  32'(m_sel(i)));
        check({tag, ".an_n"},  32'(an),   32'(m_an(i)));
        check({tag, ".ready"}, 32'(rdy),  32'(!m_full[i]));
        check({tag, ".fd"},    32'(fd),   32'(m_fd[i]));
        check({tag, ".disp"},  32'(disp), 32'(m_disp[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp_inst(0, "a", a_sel, a_an, a_rdy, a_fd, a_disp);
        cmp_inst(1, "b", b_sel, b_an, b_rdy, b_fd, b_disp);
    endtask

    task automatic wait_fd(input string name);
        for (int n = 0; n < 40 && !a_fd; n++) step();
        check({name, ".wait_fd"}, 32'(a_fd), 32'd1);
    endtask

    typedef struct {
        logic        rst_n, en, lz, valid;
        logic [15:0] data;
        logic [3:0]  sel, an;
        logic        rdy, fd;
        logic [15:0] disp;
    } vec_t;

    vec_t tbl[9];
    int   stay;

    initial begin
        rst_n = 1'b0; en = 1'b1; lz_blank = 1'b0; load_valid = 1'b0; load_data = '0;

        //          rst en lz vld data      sel      an_n     rdy fd disp
        tbl[0] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,4'b0001,4'b1110,1'b1,1'b0,16'h0000};
        tbl[1] = '{1'b1,1'b1,1'b0,1'b0,16'h0000,4'b0001,4'b1110,1'b1,1'b0,16'h0000};
        tbl[2] = '{1'b1,1'b1,1'b0,1'b0,16'h0000,4'b0001,4'b1110,1'b1,1'b0,16'h0000};
        tbl[3] = '{1'b1,1'b1,1'b0,1'b0,16'h0000,4'b0001,4'b1110,1'b1,1'b0,16'h0000};
        tbl[4] = '{1'b1,1'b1,1'b0,1'b0,16'h0000,4'b0010,4'b1101,1'b1,1'b0,16'h0000};
        tbl[5] = '{1'b1,1'b1,1'b0,1'b1,16'h1234,4'b0010,4'b1101,1'b0,1'b0,16'h0000};
        tbl[6] = '{1'b1,1'b1,1'b0,1'b1,16'hBEEF,4'b0010,4'b1101,1'b0,1'b0,16'h0000};
        tbl[7] = '{1'b1,1'b0,1'b0,1'b0,16'h0000,4'b0010,4'b1111,1'b0,1'b0,16'h0000};
        tbl[8] = '{1'b1,1'b1,1'b1,1'b0,16'h0000,4'b0010,4'b1111,1'b0,1'b0,16'h0000};

        for (int v = 0; v < 9; v++) begin
            rst_n = tbl[v].rst_n; en = tbl[v].en; lz_blank = tbl[v].lz;
            load_valid = tbl[v].valid; load_data = tbl[v].data;
            step();
            check($sformatf("vec%0d.sel", v),   32'(a_sel),  32'(tbl[v].sel));
            check($sformatf("vec%0d.an_n", v),  32'(a_an),   32'(tbl[v].an));
            check($sformatf("vec%0d.ready", v), 32'(a_rdy),  32'(tbl[v].rdy));
            check($sformatf("vec%0d.fd", v),    32'(a_fd),   32'(tbl[v].fd));
            check($sformatf("vec%0d.disp", v),  32'(a_disp), 32'(tbl[v].disp));
            $display("vec %0d: sel=%b an_n=%b ready=%b fd=%b disp=%h",
                     v, a_sel, a_an, a_rdy, a_fd, a_disp);
        end

        // 1234 pending: appears with frame_done, ready reopens on the same edge.
        lz_blank = 1'b0; load_valid = 1'b0;
        wait_fd("swap1234");
        check("swap1234.disp",  32'(a_disp), 32'h1234);
        check("swap1234.ready", 32'(a_rdy),  32'd1);
        check("swap1234.sel",   32'(a_sel),  32'd1);
        $display("swap: disp=%h ready=%b", a_disp, a_rdy);

        // BEEF shown one full frame (16 clk) later.
        load_valid = 1'b1; load_data = 16'hBEEF;
        step();
        check("beef.accept_ready", 32'(a_rdy), 32'd0);
        load_valid = 1'b0;
        stay = 1;
        for (int n = 0; n < 40 && !a_fd; n++) begin
            step();
            stay++;
        end
        check("beef.frame_len", 32'(stay), 32'd16);
        check("beef.disp",      32'(a_disp), 32'hBEEF);
        $display("swap: disp=%h after %0d clk", a_disp, stay);

        // Leading-zero blanking on 0050: digits 3 and 2 stay dark.
        load_valid = 1'b1; load_data = 16'h0050;
        step();
        load_valid = 1'b0;
        wait_fd("lz0050");
        lz_blank = 1'b1;
        for (int n = 0; n < 16; n++) begin
            #1;
            check("lz0050.an_n", 32'(a_an),
                  32'(a_sel[0] ? 4'b1110 : a_sel[1] ? 4'b1101 : 4'b1111));
            step();
        end
        lz_blank = 1'b0;

        // Freeze while digit 2 is selected, one tick into its dwell.
        for (int n = 0; n < 20 && a_sel != 4'b0100; n++) step();
        check("freeze.reach_sel", 32'(a_sel), 32'b0100);
        step();
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            check("freeze.an_n", 32'(a_an), 32'hF);
            check("freeze.sel",  32'(a_sel), 32'b0100);
            check("freeze.fd",   32'(a_fd), 32'd0);
        end
        en = 1'b1;
        step();
        check("resume.sel1", 32'(a_sel), 32'b0100);
        step();
        check("resume.sel2", 32'(a_sel), 32'b0100);
        step();
        check("resume.sel3", 32'(a_sel), 32'b1000);
        $display("resume: sel=%b", a_sel);

        // Reset with pending full at sel=1000 discards the pending value.
        load_valid = 1'b1; load_data = 16'h7777;
        step();
        check("rst.pend_full", 32'(a_rdy), 32'd0);
        load_valid = 1'b0; rst_n = 1'b0;
        step();
        check("rst.sel",   32'(a_sel),  32'b0001);
        check("rst.an_n",  32'(a_an),   32'b1110);
        check("rst.ready", 32'(a_rdy),  32'd1);
        check("rst.fd",    32'(a_fd),   32'd0);
        check("rst.disp",  32'(a_disp), 32'h0000);
        rst_n = 1'b1;
        wait_fd("rst.frame");
        check("rst.discarded", 32'(a_disp), 32'h0000);
        $display("reset: disp=%h ready=%b", a_disp, a_rdy);

        // Random traffic against the model for both instances.
        for (int n = 0; n < 1500; n++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            en         = ($urandom_range(0, 7) != 0);
            lz_blank   = 1'($urandom_range(0, 1));
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom) >> (4 * $urandom_range(0, 3));
            step();
            if (load_valid && rst_n && !a_rdy)
                $display("rand %0d: load %h disp=%h sel=%b", n, load_data, a_disp, a_sel);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
